stage2_pool2d_stream: RTL

- Parametrised successor to the stage-2 per-point pooling core.
- Performs 2x2, stride-2 pooling on a raster-ordered multi-channel feature map streamed one spatial point per valid cycle, all channels in parallel.
- Keeps its own row/column position and a half-width line buffer, so the upstream convolution stage only streams points.
- Supports signed max pooling or average pooling, selected by parameter, and flags the end of each frame.

---
 rtl/stage2_pool2d_stream.sv | 129 ++++++++++++
 1 files changed

// File: rtl/stage2_pool2d_stream.sv
// -----------------------------------------------------------------------------
// stage2_pool2d_stream
//   2x2, stride-2 pooling over a raster-ordered, multi-channel feature map.
//   One spatial point arrives per valid cycle with all CH channels side by
//   side. The block tracks its own row/column position and keeps a half-width
//   line buffer, so the upstream stage only has to stream points.
//   MODE 0 = signed max pooling, MODE 1 = average pooling (floor).
//
// Ports
//   clk           clock
//   reset_n       asynchronous active-low reset
//   i_clear       synchronous clear of position/pending state (beats i_in_valid)
//   i_in_valid    one input point present this cycle
//   i_in_fmap     CH*IBW input point, channel c at [c*IBW +: IBW], signed
//   o_ot_valid    single-cycle pulse, one pooled point present
//   o_ot_fmap     CH*IBW pooled point, same packing; held between pulses
//   o_frame_done  pulses with the last pooled point of a frame
// -----------------------------------------------------------------------------
module stage2_pool2d_stream #(
    parameter int CH    = 3,
    parameter int IBW   = 19,
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int MODE  = 0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                i_clear,
    input  logic                i_in_valid,
    input  logic [CH*IBW-1:0]   i_in_fmap,
    output logic                o_ot_valid,
    output logic [CH*IBW-1:0]   o_ot_fmap,
    output logic                o_frame_done
);

    localparam int CW   = $clog2(IMG_W);
    localparam int RW   = $clog2(IMG_H);
    localparam int LB_D = IMG_W / 2;
    localparam int LIW  = (LB_D > 1) ? $clog2(LB_D) : 1;
    // Average mode needs two guard bits: a sum of four IBW-bit values.
    localparam int AW   = (MODE == 1) ? IBW + 2 : IBW;

    // Pairwise pooling operator in the widened accumulation domain.
    function automatic logic signed [AW-1:0] op(input logic signed [AW-1:0] a,
                                                input logic signed [AW-1:0] b);
        if (MODE == 1) op = a + b;
        else           op = (a > b) ? a : b;
    endfunction

    logic [CW-1:0]          col;
    logic [RW-1:0]          row;
    logic [LIW-1:0]         lb_idx;
    logic                   col_last;
    logic                   row_last;
    logic                   accept;

    logic signed [IBW-1:0]  hold    [CH];
    logic signed [AW-1:0]   linebuf [LB_D][CH];
    logic signed [IBW-1:0]  x       [CH];
    logic signed [AW-1:0]   pair    [CH];
    logic signed [AW-1:0]   quad    [CH];
    logic signed [IBW-1:0]  pooled  [CH];

    // A clear wins over a simultaneous input: that input is dropped entirely.
    assign accept   = i_in_valid && !i_clear;
    assign col_last = (col == CW'(IMG_W - 1));
    assign row_last = (row == RW'(IMG_H - 1));
    assign lb_idx   = LIW'(col >> 1);

    // NOTE: every always_comb output is written on every path (here each loop
    // iteration assigns all four arrays unconditionally), so no latch is inferred.
    always_comb begin
        for (int c = 0; c < CH; c++) begin
            x[c]    = i_in_fmap[c*IBW +: IBW];
            pair[c] = op(AW'(hold[c]), AW'(x[c]));
            quad[c] = op(linebuf[lb_idx][c], pair[c]);
            // Arithmetic shift gives floor division; the result always fits IBW.
            pooled[c] = (MODE == 1) ? IBW'(quad[c] >>> 2) : IBW'(quad[c]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side sees the pre-edge value regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col          <= '0;
            row          <= '0;
            o_ot_valid   <= 1'b0;
            o_ot_fmap    <= '0;
            o_frame_done <= 1'b0;
            for (int c = 0; c < CH; c++) hold[c] <= '0;
        end else begin
            o_ot_valid   <= 1'b0;
            o_frame_done <= 1'b0;
            if (i_clear) begin
                col <= '0;
                row <= '0;
            end else if (i_in_valid) begin
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end

                if (!col[0]) begin
                    for (int c = 0; c < CH; c++) hold[c] <= x[c];
                end

                // Bottom-right corner of a 2x2 window completes one output.
                if (col[0] && row[0]) begin
                    o_ot_valid   <= 1'b1;
                    o_frame_done <= col_last && row_last;
                    for (int c = 0; c < CH; c++)
                        o_ot_fmap[c*IBW +: IBW] <= pooled[c];
                end
            end
        end
    end

    // NOTE: the line buffer is a plain memory with no reset; every entry is
    // written on an even row before any odd row reads it.
    always_ff @(posedge clk) begin
        if (accept && col[0] && !row[0]) begin
            for (int c = 0; c < CH; c++) linebuf[lb_idx][c] <= pair[c];
        end
    end

endmodule
